// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered
// per-cycle status pulses.
//
// Parameters:
//   FIFO_WIDTH  data word width in bits
//   FIFO_DEPTH  number of storage entries (>= 2, any value)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   data_out     registered read data, valid one clock after an accepted read
//   wr_ack       registered: previous-cycle write accepted
//   overflow     registered: previous-cycle write rejected because full
//   underflow    registered: previous-cycle read rejected because empty
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count == FIFO_DEPTH-1
//   almostempty  count == 1
module sync_fifo #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrMax  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntAF   = CntW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, overflow_q, underflow_q;

    logic wr_acc, rd_acc;

    // Flags decode the registered count directly, so they track the post-edge
    // occupancy within the same cycle.
    always_comb begin
        full        = (count_q == CntFull);
        empty       = (count_q == '0);
        almostfull  = (count_q == CntAF);
        almostempty = (count_q == CntOne);
    end

    always_comb begin
        wr_acc = wr_en && !full;
        rd_acc = rd_en && !empty;

        // Explicit wrap compare: depth need not be a power of two.
        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrOne;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrOne;
        end

        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // No bypass: a word written on this edge is read from mem no earlier
        // than the next edge.
        data_out_d = rd_acc ? mem[rd_ptr_q] : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty;
        end
    end

    // Storage is not reset; stale entries are unreachable because reads are
    // gated by count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo. A queue-based reference
// model predicts occupancy, read data and the per-cycle status pulses.
module tb_sync_fifo;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, empty, almostfull, almostempty;

    sync_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model state.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_ack, m_ovf, m_unf;

    // {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}
    logic [6:0] obs;
    assign obs = {full, empty, almostfull, almostempty, wr_ack, overflow, underflow};

    function automatic logic [6:0] exp_status();
        int sz;
        sz = q.size();
        return {sz == DEPTH, sz == 0, sz == DEPTH - 1, sz == 1, m_ack, m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Drive one cycle, advance the model at the edge, return 1 time unit later.
    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
        logic was_full, was_empty;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        if (rst_n) begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_ack = w && !was_full;
            m_ovf = w && was_full;
            m_unf = r && was_empty;
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs !== 7'b0100000 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_poweron: status=%b dout=%h, required status=0100000 dout=0000",
                     obs, data_out);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(16'h0500 + i));
        cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (obs !== exp_status() || data_out !== 16'h0500) begin
            n_err++;
            $display("FAIL reset_prefill: status=%b dout=%h, required status=%b dout=0500",
                     obs, data_out, exp_status());
        end
        // Mid-cycle asynchronous assertion with count = 5.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== 7'b0100000 || data_out !== '0) begin
            n_err++;
            $display("FAIL reset_async: status=%b dout=%h, required status=0100000 dout=0000",
                     obs, data_out);
        end
        cycle(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            n_cmp++;
            if (obs !== 7'b0100000 || data_out !== '0) begin
                n_err++;
                $display("FAIL reset_idle%0d: status=%b dout=%h, required status=0100000 dout=0000",
                         i, obs, data_out);
            end
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, W'(i));
            n_cmp++;
            if (obs !== exp_status() || wr_ack !== 1'b1) begin
                n_err++;
                $display("FAIL fill_w%0d: status=%b, required %b with wr_ack=1",
                         i, obs, exp_status());
            end
        end
        n_cmp++;
        if (full !== 1'b1 || almostfull !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: full=%b almostfull=%b, required full=1 almostfull=0",
                     full, almostfull);
        end
        cycle(1'b1, 1'b0, 16'hDEAD);
        n_cmp++;
        if (overflow !== 1'b1 || wr_ack !== 1'b0 || full !== 1'b1 || obs !== exp_status()) begin
            n_err++;
            $display("FAIL overflow: status=%b, required %b (overflow=1 wr_ack=0 full=1)",
                     obs, exp_status());
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (data_out !== W'(i) || obs !== exp_status()) begin
                n_err++;
                $display("FAIL drain_r%0d: dout=%h status=%b, required dout=%h status=%b",
                         i, data_out, obs, W'(i), exp_status());
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty: empty=%b, required 1", empty);
        end
        cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (underflow !== 1'b1 || data_out !== 16'h0008 || obs !== exp_status()) begin
            n_err++;
            $display("FAIL underflow: underflow=%b dout=%h status=%b, required 1 / 0008 / %b",
                     underflow, data_out, obs, exp_status());
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b1, 16'h00AA);
        n_cmp++;
        if (obs !== 7'b0001101 || obs !== exp_status()) begin
            n_err++;
            $display("FAIL simul_empty: status=%b, required 0001101", obs);
        end
        for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b0, W'(16'h00B0 + i));
        cycle(1'b1, 1'b1, 16'hBEEF);
        n_cmp++;
        if (obs !== 7'b0010010 || data_out !== 16'h00AA || obs !== exp_status()) begin
            n_err++;
            $display("FAIL simul_full: status=%b dout=%h, required status=0010010 dout=00aa",
                     obs, data_out);
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (data_out !== m_dout || obs !== exp_status()) begin
                n_err++;
                $display("FAIL simul_drain%0d: dout=%h status=%b, required dout=%h status=%b",
                         i, data_out, obs, m_dout, exp_status());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(16'h0300 + i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(16'h0100 + i));
        n_cmp++;
        if (full !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_full: full=%b, required 1", full);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (data_out !== W'(16'h0100 + i) || obs !== exp_status()) begin
                n_err++;
                $display("FAIL wrap_r%0d: dout=%h status=%b, required dout=%h status=%b",
                         i, data_out, obs, W'(16'h0100 + i), exp_status());
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_empty: empty=%b, required 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(16'h0200 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, W'(16'h0204 + i));
            n_cmp++;
            if (data_out !== W'(16'h0200 + i) || obs !== 7'b0000100) begin
                n_err++;
                $display("FAIL stream%0d: dout=%h status=%b, required dout=%h status=0000100",
                         i, data_out, obs, W'(16'h0200 + i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, '0);
            n_cmp++;
            if (data_out !== W'(16'h0214 + i) || obs !== exp_status()) begin
                n_err++;
                $display("FAIL stream_tail%0d: dout=%h status=%b, required dout=%h status=%b",
                         i, data_out, obs, W'(16'h0214 + i), exp_status());
            end
        end
    endtask

    task automatic test_random();
        logic w, r;
        for (int i = 0; i < 400; i++) begin
            // Bias toward writes in the first half and reads in the second
            // so both boundaries get exercised.
            w = ($urandom_range(0, 99) < ((i < 200) ? 65 : 35));
            r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 65));
            cycle(w, r, W'($urandom));
            n_cmp++;
            if (data_out !== m_dout || obs !== exp_status()) begin
                n_err++;
                $display("FAIL random%0d: dout=%h status=%b, required dout=%h status=%b",
                         i, data_out, obs, m_dout, exp_status());
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap();
        test_back_to_back();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Synchronous single-clock FIFO: the design under test that drives the interface the bench monitor samples.
- Accepts words on data_in when wr_en is high and returns them in order on data_out when rd_en is high.
- Reports status flags: full, empty, almostfull, almostempty, wr_ack, overflow, underflow.
- All outputs are defined so the scoreboard reference model can predict them cycle-exactly.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries; any value >= 2, not required to be a power of 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected because full.
- underflow  output  1  registered; previous-cycle read rejected because empty.
- full  output  1  combinational: count == FIFO_DEPTH.
- empty  output  1  combinational: count == 0.
- almostfull  output  1  combinational: count == FIFO_DEPTH-1.
- almostempty  output  1  combinational: count == 1.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits.
  - count, $clog2(FIFO_DEPTH)+1 bits.
  - mem[FIFO_DEPTH] of FIFO_WIDTH bits.
- Reset (rst_n low, asynchronous, takes effect immediately, any cycle including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almostfull=0, almostempty=0.
  - mem is not cleared; stale contents are never observable.
- Write accept: wr_acc = wr_en && !full.
  - Writes mem[wr_ptr] <= data_in; wr_ptr advances.
  - wr_ack=1 in the next cycle.
- Write reject: wr_en && full.
  - No state change except overflow=1 in the next cycle; wr_ack=0.
- Read accept: rd_acc = rd_en && !empty.
  - data_out <= mem[rd_ptr]; rd_ptr advances.
  - Latency: 1 clock from the rd_en sample to data_out valid.
- Read reject: rd_en && empty.
  - underflow=1 in the next cycle; data_out holds its previous value.
- data_out holds its value on every cycle without rd_acc.
- Idle cycles: wr_ack, overflow and underflow are single-cycle pulses; each is 0 on any cycle whose preceding edge had no corresponding event.
- Pointer wrap: a pointer equal to FIFO_DEPTH-1 advances to 0 (explicit compare, not natural overflow).
- count update:
  - +1 on wr_acc && !rd_acc.
  - -1 on rd_acc && !wr_acc.
  - Unchanged when both or neither occur.
  - count never exceeds FIFO_DEPTH and never goes below 0.
- Simultaneous wr_en and rd_en:
  - Empty: the write is accepted; the read is rejected (underflow=1, wr_ack=1); count becomes 1.
  - Full: the read is accepted; the write is rejected (overflow=1, wr_ack=0); count becomes FIFO_DEPTH-1.
  - Otherwise: both are accepted and count is unchanged.
- Flags are purely combinational from count, so they reflect the post-edge count in the same cycle.
- No read-during-write bypass: a word written this edge is readable no earlier than the next edge.

Test Plan:
- Reset then idle:
  - Assert rst_n=0 mid-cycle with count=5.
  - Required immediately: empty=1, full=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Required after release with wr_en=rd_en=0: all outputs stay unchanged.
- Fill and overflow:
  - Write 0x0001..0x0008 on 8 consecutive cycles. Required: wr_ack=1 on each following cycle; almostfull=1 after the 7th write; full=1 after the 8th.
  - 9th write of 0xDEAD. Required: overflow=1, wr_ack=0, count stays 8.
- Drain and underflow:
  - From full, read 8 times. Required: data_out = 0x0001..0x0008 in order, one cycle after each rd_en; almostempty=1 when count=1; empty=1 after the 8th read.
  - 9th read. Required: underflow=1, data_out holds 0x0008.
- Simultaneous at boundaries:
  - Empty, wr_en=rd_en=1 with data_in=0x00AA. Required: wr_ack=1, underflow=1, count=1, almostempty=1.
  - Full, wr_en=rd_en=1. Required: overflow=1, count=7, data_out = oldest word.
- Wrap-around:
  - Write 6 words, read 6, then write 8 words 0x0100..0x0107 and read 8.
  - Required: exact order 0x0100..0x0107 with no loss across the pointer wrap; count back to 0.
- Steady concurrent stream:
  - With count=4, wr_en=rd_en=1 for 20 cycles with an incrementing data_in.
  - Required: count stays 4 throughout, full, empty, almostfull and almostempty all stay 0, and data_out lags data_in by exactly 4 accepted words.
